line_serializer: RTL and testbench

- Parallel-to-serial converter: accepts one 128-bit cache line in a single cycle and emits it as four 32-bit words over a valid/ready stream.
- Sits on the cache-to-memory writeback path.
- Opposite end of the word-accumulating line fill path: a word stream shifted into a 128-bit shift register (newest word at [127:96]) reconstructs the original line exactly.

---
 rtl/line_serializer.sv | 101 ++++++++++
 tb/tb_line_serializer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_serializer.sv
// Serializes one WORD_W*WORDS line into WORDS words, lowest word first, over a valid/ready stream.
// Define LINE_SERIALIZER_BACK2BACK_EN to accept the next line during the last word transfer (zero bubbles).
module line_serializer #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     load_valid,
    input  logic [WORD_W*WORDS-1:0]  load_data,
    output logic                     load_ready,
    output logic                     word_valid,
    output logic [WORD_W-1:0]        word_data,
    output logic                     word_last,
    input  logic                     word_ready,
    output logic                     busy
);

    localparam int LINE_W = WORD_W * WORDS;
    localparam int CNT_W  = $clog2(WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic                last_word;
    logic                xfer;
    logic                accept;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            line_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        load_ready = 1'b0;
        accept     = 1'b0;
        last_word  = (cnt_q == CNT_LAST);
        xfer       = valid_q && word_ready;

        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
                accept     = load_valid;
            end
            SEND: begin
`ifdef LINE_SERIALIZER_BACK2BACK_EN
                load_ready = word_ready && last_word;
                accept     = load_valid && word_ready && last_word;
`endif
                // The line register empties itself as words leave, so word_data is always bit 0 upward.
                if (xfer) begin
                    line_d = line_q >> WORD_W;
                    if (last_word) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (accept) begin
            line_d  = load_data;
            cnt_d   = '0;
            state_d = SEND;
            valid_d = 1'b1;
        end
    end

    assign word_valid = valid_q;
    assign word_data  = line_q[WORD_W-1:0];
    assign word_last  = valid_q && last_word;
    assign busy       = valid_q;

endmodule

// File: tb/tb_line_serializer.sv
// Bench for line_serializer: a word-queue model checked every cycle, plus directed literal checks.
module tb_line_serializer;

    localparam int WORD_W = 32;
    localparam int WORDS  = 4;
    localparam int LINE_W = WORD_W * WORDS;
`ifdef LINE_SERIALIZER_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif
    localparam int EXP_B2B_CYC = B2B ? 8 : 9;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              load_valid = 1'b0;
    logic [LINE_W-1:0] load_data = '0;
    logic              load_ready;
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_last;
    logic              word_ready = 1'b0;
    logic              busy;

    line_serializer #(.WORD_W(WORD_W), .WORDS(WORDS)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_last  (word_last),
        .word_ready (word_ready),
        .busy       (busy)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the words of the currently held line still to be accepted.
    logic [WORD_W-1:0] mq[$];
    bit                chk_en = 1'b0;
    int                cyc = 0;
    bit                m_lr, m_xf;

    bit                obs_xfer = 1'b0;
    logic [WORD_W-1:0] obs_word;
    logic              obs_last;

    logic [WORD_W-1:0] log_w[$];
    logic              log_l[$];
    int                log_c[$];
    int                acc_c[$];

    function automatic bit exp_lr();
        return (mq.size() == 0) || (B2B && mq.size() == 1 && word_ready === 1'b1);
    endfunction

    always @(negedge Clk) begin
        if (chk_en) begin
            check("word_valid", word_valid, mq.size() > 0);
            check("busy", busy, mq.size() > 0);
            check("load_ready", load_ready, exp_lr());
            check("word_last", word_last, mq.size() == 1);
            if (mq.size() > 0)
                check("word_data", word_data, mq[0]);
            obs_xfer = word_valid && word_ready;
            obs_word = word_data;
            obs_last = word_last;
        end
    end

    always @(posedge Clk) begin
        cyc++;
        if (Reset) begin
            mq.delete();
            chk_en = 1'b1;
        end else begin
            m_lr = exp_lr();
            m_xf = (mq.size() > 0) && word_ready;
            if (obs_xfer) begin
                log_w.push_back(obs_word);
                log_l.push_back(obs_last);
                log_c.push_back(cyc);
            end
            if (m_xf)
                void'(mq.pop_front());
            if (load_valid && m_lr) begin
                acc_c.push_back(cyc);
                for (int k = 0; k < WORDS; k++)
                    mq.push_back(load_data[k*WORD_W +: WORD_W]);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_log();
        log_w.delete();
        log_l.delete();
        log_c.delete();
        acc_c.delete();
    endtask

    task automatic wait_words(input int n, input int lim);
        for (int i = 0; i < lim && log_w.size() < n; i++)
            tick();
        check("word_count_timeout", log_w.size() >= n, 1'b1);
    endtask

    task automatic wait_accepts(input int n, input int lim);
        for (int i = 0; i < lim && acc_c.size() < n; i++)
            tick();
        check("accept_timeout", acc_c.size() >= n, 1'b1);
    endtask

    logic [LINE_W-1:0] l1 = 128'h44444444_33333333_22222222_11111111;
    logic [LINE_W-1:0] la = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    logic [LINE_W-1:0] lb = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    logic [LINE_W-1:0] sr;
    logic [WORD_W-1:0] exp_ab[8] = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3,
                                     32'hB0B0B0B0, 32'hB1B1B1B1, 32'hB2B2B2B2, 32'hB3B3B3B3};
    logic [WORD_W-1:0] exp_l1[4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset held two cycles while a load is offered.
        Reset      = 1'b1;
        load_valid = 1'b1;
        load_data  = '1;
        word_ready = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Reset      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        check("rst_load_ready", load_ready, 1'b1);
        check("rst_word_valid", word_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_word_data", word_data, '0);
        check("rst_word_last", word_last, 1'b0);
        tick();
        check("rst_nothing_latched", word_valid, 1'b0);
        check("rst_no_words", log_w.size(), 0);

        // Basic line, no stalls.
        clear_log();
        load_data  = l1;
        load_valid = 1'b1;
        word_ready = 1'b1;
        tick();
        load_valid = 1'b0;
        load_data  = '0;
        wait_words(4, 20);
        tick();
        sr = '0;
        for (int i = 0; i < 4; i++) begin
            check("basic_word", log_w[i], exp_l1[i]);
            check("basic_last", log_l[i], i == 3);
            sr = {log_w[i], sr[LINE_W-1:WORD_W]};
        end
        check("basic_first_latency", log_c[0] - acc_c[0], 1);
        check("basic_consecutive", log_c[3] - log_c[0], 3);
        check("basic_reassembled", sr, l1);

        // Backpressure on word 1.
        clear_log();
        load_data  = l1;
        load_valid = 1'b1;
        word_ready = 1'b1;
        tick();
        load_valid = 1'b0;
        tick();
        word_ready = 1'b0;
        tick();
        check("stall_data", word_data, 32'h22222222);
        check("stall_valid", word_valid, 1'b1);
        check("stall_load_ready", load_ready, 1'b0);
        repeat (2) tick();
        word_ready = 1'b1;
        wait_words(4, 20);
        tick();
        for (int i = 0; i < 4; i++)
            check("stall_word", log_w[i], exp_l1[i]);
        check("stall_gap", log_c[1] - log_c[0], 4);

        // Reset after word 1 transfers.
        clear_log();
        load_data  = l1;
        load_valid = 1'b1;
        word_ready = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (2) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("midrst_word_valid", word_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_load_ready", load_ready, 1'b1);
        repeat (5) tick();
        check("midrst_word_count", log_w.size(), 2);

        // Back-to-back loads with load_valid held high.
        clear_log();
        word_ready = 1'b1;
        load_data  = la;
        load_valid = 1'b1;
        wait_accepts(1, 10);
        load_data = lb;
        wait_accepts(2, 20);
        load_valid = 1'b0;
        load_data  = '0;
        wait_words(8, 30);
        tick();
        for (int i = 0; i < 8; i++)
            check("b2b_word", log_w[i], exp_ab[i]);
        check("b2b_total_cycles", log_c[7] - log_c[0] + 1, EXP_B2B_CYC);

        // New data offered during SEND must not disturb the held line.
        clear_log();
        word_ready = 1'b1;
        load_data  = l1;
        load_valid = 1'b1;
        tick();
        load_data = '1;
        wait_accepts(2, 20);
        load_valid = 1'b0;
        load_data  = '0;
        wait_words(8, 30);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("ignore_word", log_w[i], exp_l1[i]);
            check("ignore_next_word", log_w[i+4], 32'hFFFFFFFF);
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
